cv32e40p_ft_nway_voter: RTL and testbench
=========================================

# cv32e40p_ft_nway_voter

Parametrised N-lane majority voter with integrated per-lane breakage monitoring and a registered output stage. It is used for the triplicated or quintuplicated datapaths of cv32e40p fault-tolerant units.
- Votes a WIDTH-bit word across NLANES replicas, excluding lanes already marked broken.
- Tracks each lane's health with a saturating error counter and a per-lane state machine.
- Optionally re-admits a broken lane after a probation window.
- Replaces the fixed 3-lane voter plus external breakage-monitor pairing.

## Interface
Parameters:
- WIDTH, 32, bits per lane word
- NLANES, 3, replica count; legal values 3 and 5
- INCREMENT, 4, counter step on a lane error
- DECREMENT, 1, counter step on a clean cycle
- THRESHOLD, 16, counter value at which the lane goes BROKEN; must be ≤ 2^COUNT_BIT−1
- COUNT_BIT, 5, counter width
- RECOVERY_CYCLES, 8, consecutive agreeing cycles needed to leave PROBATION

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  lane words valid this cycle
- data_i  in  NLANES*WIDTH  lane words; lane i occupies bits [i*WIDTH +: WIDTH]
- set_broken_i  in  NLANES  force lane to BROKEN
- valid_o  out  1  registered valid
- data_o  out  WIDTH  registered voted word
- lane_err_o  out  NLANES  registered per-lane mismatch flags
- is_broken_o  out  NLANES  lane is BROKEN or PROBATION, i.e. excluded from the vote
- err_detected_o  out  1  registered: any mismatch seen
- err_corrected_o  out  1  registered: mismatch seen and a majority exists
- fatal_o  out  1  registered: no majority possible

## Operation
- **Active set:** lanes whose state is HEALTHY or SUSPECT. Let A be the number of active lanes.
- **Vote (bitwise over active lanes):**
  - A odd: strict majority per bit.
  - A = 2 and the two lanes agree: output the common word.
  - A = 2 and the two lanes disagree: fatal; output the lower-index active lane.
  - A = 4 with a per-bit 2:2 tie: fatal; that bit is taken from the lowest-index active lane.
  - A = 1: pass-through with no detection.
  - A = 0: fatal; data = 0.
- **Mismatch:** mismatch[i] = the lane word is not equal to the voted word. It is evaluated for active lanes and for PROBATION lanes, and forced 0 for BROKEN lanes.
- **Counter update:** on each cycle with valid_i, for every active lane:
  - mismatch: counter += INCREMENT, saturating at 2^COUNT_BIT−1;
  - otherwise: counter −= DECREMENT, floored at 0.
- **Per-lane states:** HEALTHY (counter = 0), SUSPECT (counter > 0), BROKEN, PROBATION.
  - HEALTHY ↔ SUSPECT follows the counter value.
  - HEALTHY/SUSPECT → BROKEN when the updated counter ≥ THRESHOLD.
  - Any state → BROKEN on set_broken_i[i], regardless of valid_i. set_broken_i has priority over every other transition in the same cycle.
  - In BROKEN the counter is held.
  - BROKEN → PROBATION: see Configuration.
  - PROBATION: the lane is compared against the voted word on valid cycles where the result is not fatal.
    - Agreement increments a probation count.
    - Mismatch → BROKEN, probation count cleared.
    - Probation count reaching RECOVERY_CYCLES → HEALTHY, with counter and probation count cleared.
    - Fatal cycles neither advance nor reset the probation count.
- **Flags:**
  - err_detected = valid_i & (any mismatch | fatal).
  - err_corrected = err_detected & ~fatal.
  - fatal is reported only when valid_i is high.

## Timing
- **Reset:** every lane HEALTHY, counters and probation counts 0. valid_o, data_o, lane_err_o, is_broken_o, err_detected_o, err_corrected_o and fatal_o are all 0.
- **Latency:** one cycle from valid_i/data_i to valid_o and the registered flags. data_o, lane_err_o and the flags are loaded only when valid_i is high. valid_o follows valid_i with one cycle of delay.
- **State changes:** lane states update at the same edge that registers the output. A lane that goes BROKEN at edge k is excluded from the vote computed in the cycle after edge k. is_broken_o is a direct decode of the state register, so it has no extra delay.
- **Backpressure:** none; one word per cycle, and the consumer must accept it.
- **Reset mid-stream:** any in-flight word is dropped, and valid_o is low in the cycle after reset is released.

## Configuration
- **FT_LANE_RECOVERY_EN defined:** BROKEN → PROBATION on the next clock edge at which set_broken_i[i] is low. PROBATION behaves as described under Operation.
- **FT_LANE_RECOVERY_EN undefined:** the PROBATION state and probation counters are not built. BROKEN is sticky until rst.

## Test plan
- **Single-lane fault, NLANES=3:** lane 1 = 0xDEADBEEF, others 0x12345678, for 1 valid cycle → next cycle data_o = 0x12345678, lane_err_o = 3'b010, err_corrected_o = 1, lane 1 SUSPECT with counter 4.
- **Threshold:** lane 2 faulty for 4 consecutive valid cycles → counter 16; is_broken_o[2] rises after the 4th edge; subsequent 0xA/0xA votes report no error.
- **Two-active disagreement:** set_broken_i[0] held; lanes 1 and 2 = 0x1 and 0x2 → fatal_o = 1, data_o = 0x1, err_corrected_o = 0.
- **Recovery (macro on):** release set_broken_i[0] after a 1-cycle pulse, then 8 agreeing valid cycles → is_broken_o[0] falls after the 8th edge. A mismatch at cycle 5 returns the lane to BROKEN and restarts the count.
- **NLANES=5, two faulty lanes:** lanes 0 and 3 corrupted → correct word from 3:2 vote, lane_err_o = 5'b01001.
- **Saturation and reset:** COUNT_BIT=3, INCREMENT=4, THRESHOLD=7 → counter clamps at 7 and the lane goes BROKEN. Asserting rst mid-burst clears all outputs asynchronously.

Source files
------------

// File: rtl/cv32e40p_ft_nway_voter.sv
// N-lane bitwise majority voter with per-lane health tracking and a registered output stage.
// Define FT_LANE_RECOVERY_EN to build the probation path that re-admits broken lanes.
module cv32e40p_ft_nway_voter #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned NLANES          = 3,
  parameter int unsigned INCREMENT       = 4,
  parameter int unsigned DECREMENT       = 1,
  parameter int unsigned THRESHOLD       = 16,
  parameter int unsigned COUNT_BIT       = 5,
  parameter int unsigned RECOVERY_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [NLANES*WIDTH-1:0]  data_i,
  input  logic [NLANES-1:0]        set_broken_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [NLANES-1:0]        lane_err_o,
  output logic [NLANES-1:0]        is_broken_o,
  output logic                     err_detected_o,
  output logic                     err_corrected_o,
  output logic                     fatal_o
);

  localparam int unsigned CntMax = (2 ** COUNT_BIT) - 1;

  if (!(NLANES == 3 || NLANES == 5)) begin : g_bad_nlanes
    $error("cv32e40p_ft_nway_voter: NLANES must be 3 or 5");
  end
  if (THRESHOLD > CntMax || THRESHOLD == 0 || RECOVERY_CYCLES == 0) begin : g_bad_cfg
    $error("cv32e40p_ft_nway_voter: illegal THRESHOLD or RECOVERY_CYCLES");
  end

  typedef enum logic [1:0] {StHealthy, StSuspect, StBroken, StProbation} lane_state_e;

  lane_state_e                      state_q [NLANES];
  lane_state_e                      state_d [NLANES];
  logic [NLANES-1:0][COUNT_BIT-1:0] cnt_q, cnt_d;
`ifdef FT_LANE_RECOVERY_EN
  localparam int unsigned ProbW = $clog2(RECOVERY_CYCLES + 1);
  logic [NLANES-1:0][ProbW-1:0]     prob_q, prob_d;
`endif

  logic [NLANES-1:0][WIDTH-1:0] lane;
  logic [NLANES-1:0]            active;
  logic [NLANES-1:0]            mismatch;
  logic [WIDTH-1:0]             voted;
  logic [WIDTH-1:0]             lead;
  logic                         fatal;

  logic                         valid_q;
  logic [WIDTH-1:0]             data_q;
  logic [NLANES-1:0]            lane_err_q;
  logic                         err_det_q;
  logic                         err_cor_q;
  logic                         fatal_q;

  assign lane = data_i;

  // Vote. Even active counts may tie per bit; a tie takes the lowest active lane's bit and is
  // fatal. With no active lanes every bit ties (0 == 0), so A = 0 is fatal with data 0.
  always_comb begin
    int unsigned n_act;
    int unsigned ones;
    logic        found;
    logic        tie;
    n_act  = 0;
    ones   = 0;
    found  = 1'b0;
    tie    = 1'b0;
    lead   = '0;
    voted  = '0;
    active = '0;
    for (int i = 0; i < NLANES; i++) begin
      active[i] = (state_q[i] == StHealthy) || (state_q[i] == StSuspect);
      if (active[i]) begin
        n_act = n_act + 1;
        if (!found) begin
          lead  = lane[i];
          found = 1'b1;
        end
      end
    end
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < NLANES; i++) begin
        if (active[i] && lane[i][b]) ones = ones + 1;
      end
      if (2 * ones > n_act) begin
        voted[b] = 1'b1;
      end else if (2 * ones == n_act) begin
        voted[b] = lead[b];
        tie      = 1'b1;
      end
    end
    fatal = tie;
  end

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NLANES; i++) begin
      mismatch[i] = (state_q[i] != StBroken) && (lane[i] != voted);
    end
  end

  always_comb begin
    int unsigned sum;
    sum = 0;
    for (int i = 0; i < NLANES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef FT_LANE_RECOVERY_EN
      prob_d[i]  = prob_q[i];
`endif
      case (state_q[i])
        StHealthy, StSuspect: begin
          if (valid_i) begin
            if (mismatch[i]) begin
              sum      = 32'(cnt_q[i]) + INCREMENT;
              cnt_d[i] = (sum > CntMax) ? COUNT_BIT'(CntMax) : COUNT_BIT'(sum);
            end else begin
              cnt_d[i] = (32'(cnt_q[i]) < DECREMENT) ? '0 : cnt_q[i] - COUNT_BIT'(DECREMENT);
            end
            if (32'(cnt_d[i]) >= THRESHOLD) state_d[i] = StBroken;
            else if (cnt_d[i] == '0)        state_d[i] = StHealthy;
            else                            state_d[i] = StSuspect;
          end
        end
`ifdef FT_LANE_RECOVERY_EN
        StBroken: begin
          state_d[i] = StProbation;
          prob_d[i]  = '0;
        end
        StProbation: begin
          if (valid_i && !fatal) begin
            if (mismatch[i]) begin
              state_d[i] = StBroken;
              prob_d[i]  = '0;
            end else if (32'(prob_q[i]) + 32'd1 >= RECOVERY_CYCLES) begin
              state_d[i] = StHealthy;
              cnt_d[i]   = '0;
              prob_d[i]  = '0;
            end else begin
              prob_d[i]  = prob_q[i] + ProbW'(1);
            end
          end
        end
`else
        StBroken: state_d[i] = StBroken;
`endif
        default: state_d[i] = StBroken;
      endcase
      if (set_broken_i[i]) begin
        state_d[i] = StBroken;
`ifdef FT_LANE_RECOVERY_EN
        prob_d[i]  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NLANES; i++) state_q[i] <= StHealthy;
      cnt_q  <= '0;
`ifdef FT_LANE_RECOVERY_EN
      prob_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NLANES; i++) state_q[i] <= state_d[i];
      cnt_q  <= cnt_d;
`ifdef FT_LANE_RECOVERY_EN
      prob_q <= prob_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      lane_err_q <= '0;
      err_det_q  <= 1'b0;
      err_cor_q  <= 1'b0;
      fatal_q    <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q     <= voted;
        lane_err_q <= mismatch;
        err_det_q  <= (|mismatch) | fatal;
        err_cor_q  <= ((|mismatch) | fatal) & ~fatal;
        fatal_q    <= fatal;
      end
    end
  end

  always_comb begin
    is_broken_o = '0;
    for (int i = 0; i < NLANES; i++) begin
      is_broken_o[i] = (state_q[i] == StBroken) || (state_q[i] == StProbation);
    end
  end

  assign valid_o         = valid_q;
  assign data_o          = data_q;
  assign lane_err_o      = lane_err_q;
  assign err_detected_o  = err_det_q;
  assign err_corrected_o = err_cor_q;
  assign fatal_o         = fatal_q;

endmodule

// File: tb/tb_cv32e40p_ft_nway_voter.sv
// Directed bench for cv32e40p_ft_nway_voter: 3-lane default, 5-lane, and 3-bit-counter builds.
module tb_cv32e40p_ft_nway_voter;

  logic clk;
  logic rst;
  logic valid;

  logic [95:0]  d3;
  logic [2:0]   sb3;
  logic         v3, ed3, ec3, f3;
  logic [31:0]  q3;
  logic [2:0]   le3, ib3;

  logic [159:0] d5;
  logic [4:0]   sb5;
  logic         v5, ed5, ec5, f5;
  logic [31:0]  q5;
  logic [4:0]   le5, ib5;

  logic [23:0]  ds;
  logic [2:0]   sbs;
  logic         vs, eds, ecs, fs;
  logic [7:0]   qs;
  logic [2:0]   les, ibs;

  int n_total;
  int n_bad;

  cv32e40p_ft_nway_voter u3 (
    .clk(clk), .rst(rst), .valid_i(valid), .data_i(d3), .set_broken_i(sb3),
    .valid_o(v3), .data_o(q3), .lane_err_o(le3), .is_broken_o(ib3),
    .err_detected_o(ed3), .err_corrected_o(ec3), .fatal_o(f3)
  );

  cv32e40p_ft_nway_voter #(.NLANES(5)) u5 (
    .clk(clk), .rst(rst), .valid_i(valid), .data_i(d5), .set_broken_i(sb5),
    .valid_o(v5), .data_o(q5), .lane_err_o(le5), .is_broken_o(ib5),
    .err_detected_o(ed5), .err_corrected_o(ec5), .fatal_o(f5)
  );

  cv32e40p_ft_nway_voter #(.WIDTH(8), .COUNT_BIT(3), .INCREMENT(4), .THRESHOLD(7)) us (
    .clk(clk), .rst(rst), .valid_i(valid), .data_i(ds), .set_broken_i(sbs),
    .valid_o(vs), .data_o(qs), .lane_err_o(les), .is_broken_o(ibs),
    .err_detected_o(eds), .err_corrected_o(ecs), .fatal_o(fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    valid   = 1'b0;
    d3 = '0; d5 = '0; ds = '0;
    sb3 = '0; sb5 = '0; sbs = '0;
    step();
    step();
    chk("rst_valid", v3, 0);
    chk("rst_data", q3, 0);
    chk("rst_broken", ib3, 0);
    chk("rst_flags", {ed3, ec3, f3, le3}, 0);
    rst = 1'b0;

    // Single-lane fault
    d3    = {32'h12345678, 32'hDEADBEEF, 32'h12345678};
    valid = 1'b1;
    step();
    chk("t1_valid", v3, 1);
    chk("t1_data", q3, 32'h12345678);
    chk("t1_lane_err", le3, 3'b010);
    chk("t1_det", ed3, 1);
    chk("t1_corr", ec3, 1);
    chk("t1_fatal", f3, 0);
    chk("t1_cnt", u3.cnt_q[1], 4);
    chk("t1_broken", ib3, 0);
    valid = 1'b0;
    d3    = {32'hA, 32'hA, 32'hA};
    step();
    chk("t1_valid_drop", v3, 0);
    chk("t1_data_hold", q3, 32'h12345678);
    valid = 1'b1;
    repeat (4) step();
    chk("t1_cnt_decay", u3.cnt_q[1], 0);
    chk("t1_clean_det", ed3, 0);
    chk("t1_clean_data", q3, 32'hA);

    // Threshold: lane 2 faulty for four valid cycles
    d3 = {32'hB, 32'hA, 32'hA};
    repeat (3) step();
    chk("t2_not_yet", ib3, 3'b000);
    chk("t2_lane_err", le3, 3'b100);
    chk("t2_corr", ec3, 1);
    step();
    chk("t2_broken", ib3, 3'b100);
    step();
    chk("t2_excl_err", le3, 3'b000);
    chk("t2_excl_det", ed3, 0);
    chk("t2_excl_data", q3, 32'hA);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk("t2_rst_broken", ib3, 3'b000);

    // Two active lanes disagreeing
    sb3   = 3'b001;
    valid = 1'b0;
    step();
    chk("t3_forced", ib3, 3'b001);
    valid = 1'b1;
    d3    = {32'h2, 32'h1, 32'h0};
    step();
    chk("t3_fatal", f3, 1);
    chk("t3_data", q3, 32'h1);
    chk("t3_corr", ec3, 0);
    chk("t3_det", ed3, 1);
    chk("t3_lane_err", le3, 3'b100);
    d3 = {32'h5, 32'h5, 32'h0};
    step();
    chk("t3_agree_fatal", f3, 0);
    chk("t3_agree_data", q3, 32'h5);
    chk("t3_agree_det", ed3, 0);

    // Release the forced break
    sb3 = 3'b000;
    d3  = {32'h5, 32'h5, 32'h5};
`ifdef FT_LANE_RECOVERY_EN
    step();
    chk("t4_probation", ib3, 3'b001);
    repeat (4) step();
    d3 = {32'h5, 32'h5, 32'h6};
    step();
    chk("t4_prob_err", le3, 3'b001);
    chk("t4_prob_corr", ec3, 1);
    chk("t4_rebroken", ib3, 3'b001);
    d3 = {32'h5, 32'h5, 32'h5};
    step();
    repeat (7) step();
    chk("t4_still_prob", ib3, 3'b001);
    step();
    chk("t4_recovered", ib3, 3'b000);
`else
    repeat (10) step();
    chk("t4_sticky", ib3, 3'b001);
`endif

    // Five lanes, two faulty
    d5 = {32'h00C0FFEE, 32'h0000BAD3, 32'h00C0FFEE, 32'h00C0FFEE, 32'h0000BAD0};
    step();
    chk("t5_data", q5, 32'h00C0FFEE);
    chk("t5_lane_err", le5, 5'b01001);
    chk("t5_corr", ec5, 1);
    chk("t5_fatal", f5, 0);

    // Saturation with a 3-bit counter
    ds = {8'h00, 8'hFF, 8'h00};
    step();
    chk("t6_cnt4", us.cnt_q[1], 4);
    chk("t6_not_broken", ibs, 3'b000);
    step();
    chk("t6_cnt_sat", us.cnt_q[1], 7);
    chk("t6_broken", ibs, 3'b010);
    chk("t6_lane_err", les, 3'b010);
    chk("t6_data", qs, 8'h00);

    // Asynchronous reset mid-burst
    rst = 1'b1;
    #1;
    chk("t7_valid", {v3, v5, vs}, 0);
    chk("t7_data5", q5, 0);
    chk("t7_flags", {ecs, eds, les}, 0);
    chk("t7_broken", ibs, 0);
    rst = 1'b0;
    #1;
    chk("t7_valid_after", v3, 0);
    step();
    chk("t7_resume", v3, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
